rocketcpu_uart_fifo: RTL and testbench



---
 rtl/rocketcpu_uart_fifo.sv | 198 +++++++++++++++++++
 tb/tb_rocketcpu_uart_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_uart_fifo.sv
// rocketcpu_uart_fifo: Wishbone UART with TX/RX FIFOs, runtime baud divider,
// optional parity, sticky error flags and a maskable level interrupt.
module rocketcpu_uart_fifo #(
    parameter int DEFAULT_DIV = 104,
    parameter int FIFO_AW = 4
) (
    input  logic        i_wb_clk,
    input  logic        reset,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        ser_tx,
    input  logic        ser_rx,
    output logic        irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0] r_tx_mem [DEPTH];
    logic [7:0] r_rx_mem [DEPTH];
    logic [FIFO_AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [FIFO_AW:0] r_tx_cnt, r_rx_cnt;
    logic [15:0] r_div;
    logic [4:0] r_ctrl;
    logic r_rxovr, r_ferr, r_perr, r_txovr;
    state_t r_tx_st, r_rx_st;
    logic [15:0] r_tx_ctr, r_tx_div, r_rx_ctr, r_rx_div;
    logic [2:0] r_tx_bit, r_rx_bit;
    logic [7:0] r_tx_sh, r_rx_sh;
    logic r_tx_pen, r_tx_pbit, r_rx_pen, r_rx_podd, r_rx_hold, r_rx_s1, r_rx_s2;

    logic w_acc, w_wr, w_rd, w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
    logic w_tx_wr, w_tx_push, w_tx_load, w_rx_pop, w_rx_done, w_rx_push, w_w1c;
    logic w_tx_tick, w_rx_tick, w_perr_set, w_ferr_set, w_unused;
    logic [7:0] w_tx_byte;
    logic [31:0] w_status, w_rdata;

    assign w_unused   = &{1'b0, i_wb_dat[31:16], i_wb_sel[3:1]};
    assign w_acc      = i_wb_cyc & ~o_wb_ack;
    assign w_wr       = w_acc & i_wb_we & i_wb_sel[0];
    assign w_rd       = w_acc & ~i_wb_we;
    assign w_w1c      = w_wr & (i_wb_adr == 2'd1);
    assign w_tx_empty = r_tx_cnt == '0;
    assign w_tx_full  = r_tx_cnt[FIFO_AW];
    assign w_rx_empty = r_rx_cnt == '0;
    assign w_rx_full  = r_rx_cnt[FIFO_AW];
    assign w_tx_busy  = (r_tx_st != IDLE) | ~w_tx_empty;
    assign w_tx_byte  = r_tx_mem[r_tx_rp];
    assign w_tx_tick  = r_tx_ctr == '0;
    assign w_rx_tick  = r_rx_ctr == '0;
    // A new frame starts straight out of the stop bit so queued bytes leave no gap.
    assign w_tx_load  = ~w_tx_empty & ((r_tx_st == IDLE) | ((r_tx_st == STOP) & w_tx_tick));
    assign w_tx_wr    = w_wr & (i_wb_adr == 2'd0);
    assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_load);
    assign w_rx_pop   = w_rd & (i_wb_adr == 2'd0) & ~w_rx_empty;
    assign w_rx_done  = (r_rx_st == STOP) & w_rx_tick & r_rx_s2;
    assign w_rx_push  = w_rx_done & (~w_rx_full | w_rx_pop);
    assign w_ferr_set = (r_rx_st == STOP) & w_rx_tick & ~r_rx_s2;
    assign w_perr_set = (r_rx_st == PARITY) & w_rx_tick & (r_rx_s2 != (^r_rx_sh ^ r_rx_podd));

    assign w_status = {{(15-FIFO_AW){1'b0}}, r_rx_cnt, 7'b0, r_txovr, r_perr, r_ferr, r_rxovr,
                       w_tx_busy, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};
    assign w_rdata  = (i_wb_adr == 2'd0) ? (w_rx_empty ? 32'h100 : {24'b0, r_rx_mem[r_rx_rp]}) :
                      (i_wb_adr == 2'd1) ? w_status :
                      (i_wb_adr == 2'd2) ? {16'b0, r_div} : {27'b0, r_ctrl};

    always_ff @(posedge i_wb_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_wb_dat[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            r_div    <= 16'(DEFAULT_DIV);
            r_ctrl   <= '0;
            {r_rxovr, r_ferr, r_perr, r_txovr} <= '0;
            {r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp} <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            o_wb_ack <= w_acc;
            if (w_rd) o_wb_rdt <= w_rdata;
            if (w_wr & (i_wb_adr == 2'd2)) r_div <= (i_wb_dat[15:0] < 16'd4) ? 16'd4 : i_wb_dat[15:0];
            if (w_wr & (i_wb_adr == 2'd3)) r_ctrl <= i_wb_dat[4:0];
            r_rxovr  <= (r_rxovr & ~(w_w1c & i_wb_dat[5])) | (w_rx_done & ~w_rx_push);
            r_ferr   <= (r_ferr  & ~(w_w1c & i_wb_dat[6])) | w_ferr_set;
            r_perr   <= (r_perr  & ~(w_w1c & i_wb_dat[7])) | w_perr_set;
            r_txovr  <= (r_txovr & ~(w_w1c & i_wb_dat[8])) | (w_tx_wr & ~w_tx_push);
            r_tx_wp  <= r_tx_wp + FIFO_AW'(w_tx_push);
            r_tx_rp  <= r_tx_rp + FIFO_AW'(w_tx_load);
            r_tx_cnt <= r_tx_cnt + (FIFO_AW+1)'(w_tx_push) - (FIFO_AW+1)'(w_tx_load);
            r_rx_wp  <= r_rx_wp + FIFO_AW'(w_rx_push);
            r_rx_rp  <= r_rx_rp + FIFO_AW'(w_rx_pop);
            r_rx_cnt <= r_rx_cnt + (FIFO_AW+1)'(w_rx_push) - (FIFO_AW+1)'(w_rx_pop);
            irq      <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty) |
                        (r_ctrl[2] & (r_rxovr | r_ferr | r_perr | r_txovr));
        end
    end

    // Divider and parity settings are latched per frame so mid-frame writes wait.
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            r_tx_st   <= IDLE;
            ser_tx    <= 1'b1;
            r_tx_ctr  <= '0;
            r_tx_div  <= 16'(DEFAULT_DIV);
            r_tx_bit  <= '0;
            r_tx_sh   <= '0;
            r_tx_pen  <= 1'b0;
            r_tx_pbit <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_st   <= START;
            ser_tx    <= 1'b0;
            r_tx_ctr  <= r_div - 16'd1;
            r_tx_div  <= r_div;
            r_tx_bit  <= '0;
            r_tx_sh   <= w_tx_byte;
            r_tx_pen  <= r_ctrl[3];
            r_tx_pbit <= ^w_tx_byte ^ r_ctrl[4];
        end else if (r_tx_st != IDLE) begin
            if (!w_tx_tick) r_tx_ctr <= r_tx_ctr - 16'd1;
            else begin
                r_tx_ctr <= r_tx_div - 16'd1;
                case (r_tx_st)
                    START: begin
                        ser_tx  <= r_tx_sh[0];
                        r_tx_sh <= r_tx_sh >> 1;
                        r_tx_st <= DATA;
                    end
                    DATA: begin
                        ser_tx   <= (r_tx_bit == 3'd7) ? (r_tx_pen ? r_tx_pbit : 1'b1) : r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                        r_tx_st  <= (r_tx_bit != 3'd7) ? DATA : r_tx_pen ? PARITY : STOP;
                    end
                    PARITY: begin
                        ser_tx  <= 1'b1;
                        r_tx_st <= STOP;
                    end
                    default: r_tx_st <= IDLE;
                endcase
            end
        end
    end

    // After a framing error the receiver stays disarmed until the line idles high.
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= IDLE;
            r_rx_ctr  <= '0;
            r_rx_div  <= 16'(DEFAULT_DIV);
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_pen  <= 1'b0;
            r_rx_podd <= 1'b0;
            r_rx_hold <= 1'b0;
        end else begin
            r_rx_s1 <= ser_rx;
            r_rx_s2 <= r_rx_s1;
            if (r_rx_st == IDLE) begin
                if (r_rx_hold) r_rx_hold <= ~r_rx_s2;
                else if (!r_rx_s2) begin
                    r_rx_st   <= START;
                    r_rx_ctr  <= (r_div >> 1) - 16'd1;
                    r_rx_div  <= r_div;
                    r_rx_bit  <= '0;
                    r_rx_pen  <= r_ctrl[3];
                    r_rx_podd <= r_ctrl[4];
                end
            end else if (!w_rx_tick) r_rx_ctr <= r_rx_ctr - 16'd1;
            else begin
                r_rx_ctr <= r_rx_div - 16'd1;
                case (r_rx_st)
                    START: r_rx_st <= r_rx_s2 ? IDLE : DATA;
                    DATA: begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        r_rx_st  <= (r_rx_bit != 3'd7) ? DATA : r_rx_pen ? PARITY : STOP;
                    end
                    PARITY: r_rx_st <= STOP;
                    default: begin
                        r_rx_st   <= IDLE;
                        r_rx_hold <= ~r_rx_s2;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rocketcpu_uart_fifo.sv
// tb_rocketcpu_uart_fifo: scoreboard bench for the FIFO UART; bus reads queue expected
// data for an ack monitor, a serial monitor decodes ser_tx against queued bytes.
module tb_rocketcpu_uart_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] rdt;
    logic        ack, ser_tx, irq;
    logic        rx_line = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int tx_div = 8;

    logic [31:0] exp_q[$];
    logic [31:0] msk_q[$];
    string       nm_q[$];
    logic [7:0]  txe_b[$];
    logic        txe_g[$];

    logic [31:0] mon_e, mon_m;
    string       mon_n;

    rocketcpu_uart_fifo #(.DEFAULT_DIV(104), .FIFO_AW(2)) dut (
        .i_wb_clk(clk), .reset(reset), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack),
        .ser_tx(ser_tx), .ser_rx(rx_line), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_spurious got=%h want=no_ack", rdt);
            end else begin
                mon_e = exp_q.pop_front();
                mon_m = msk_q.pop_front();
                mon_n = nm_q.pop_front();
                if (mon_m != 0) chk(mon_n, rdt & mon_m, mon_e);
            end
        end
    end

    initial begin
        logic [9:0] fr;
        logic prev;
        int st, last_st;
        prev = 1'b1;
        last_st = 0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && ser_tx === 1'b0 && !reset) begin
                st = cyc_n;
                repeat (tx_div / 2 - 1) @(negedge clk);
                fr[0] = ser_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (tx_div) @(negedge clk);
                    fr[i] = ser_tx;
                end
                if (txe_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected got=%h want=none", fr);
                end else begin
                    chk("tx_frame", 32'(fr), 32'({1'b1, txe_b.pop_front(), 1'b0}));
                    if (txe_g.pop_front()) chk("tx_gap", st - last_st, 10 * tx_div);
                end
                last_st = st;
            end
            prev = ser_tx;
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] e, input logic [31:0] m, input string nm);
        exp_q.push_back(e);
        msk_q.push_back(m);
        nm_q.push_back(nm);
        cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(negedge clk);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 4'hf, 32'h0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        bus(1'b0, a, 32'h0, 4'hf, e, 32'hffff_ffff, nm);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb, input logic sb);
        rx_line = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (8) @(negedge clk);
        end
        if (pen) begin
            rx_line = pb;
            repeat (8) @(negedge clk);
        end
        rx_line = sb;
        repeat (8) @(negedge clk);
        rx_line = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_tx(input int lim);
        int n = 0;
        while (txe_b.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain", txe_b.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ser_tx", 32'(ser_tx), 1);
        chk("reset_irq", 32'(irq), 0);
        rd(2'd1, 32'h4, "reset_status");
        rd(2'd2, 32'd104, "reset_div");
        rd(2'd0, 32'h100, "reset_data_empty");
        rd(2'd3, 32'h0, "reset_ctrl");
        wr(2'd2, 32'd2);
        rd(2'd2, 32'd4, "div_clamp");
        bus(1'b1, 2'd2, 32'd9, 4'he, 32'h0, 32'h0, "wr_nosel");
        rd(2'd2, 32'd4, "div_sel0_ignored");
        wr(2'd2, 32'd8);
        rd(2'd2, 32'd8, "div_8");

        txe_b.push_back(8'h55); txe_g.push_back(1'b0);
        txe_b.push_back(8'hA3); txe_g.push_back(1'b1);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'hA3);
        rd(2'd1, 32'h10, "status_tx_queued");
        wait_tx(400);
        rd(2'd1, 32'h4, "status_tx_done");
        wr(2'd3, 32'h2);
        chk("irq_tx_empty", 32'(irq), 1);

        wr(2'd3, 32'h1);
        chk("irq_off", 32'(irq), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("irq_rx", 32'(irq), 1);
        rd(2'd0, 32'h3C, "rx_3c");
        rd(2'd1, 32'h4, "status_rx_popped");
        chk("irq_rx_clear", 32'(irq), 0);

        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 32'h0004_0027, "status_rx_overflow");
        rd(2'd0, 32'h11, "rx_ovf_0");
        rd(2'd0, 32'h22, "rx_ovf_1");
        rd(2'd0, 32'h33, "rx_ovf_2");
        rd(2'd0, 32'h44, "rx_ovf_3");
        rd(2'd0, 32'h100, "rx_ovf_empty");
        wr(2'd1, 32'h20);
        rd(2'd1, 32'h4, "status_rxovr_clear");

        wr(2'd3, 32'h0);
        for (int i = 0; i < 5; i++) begin
            txe_b.push_back(8'hA0 + 8'(i));
            txe_g.push_back(i != 0);
        end
        for (int i = 0; i < 6; i++) wr(2'd0, 32'hA0 + i);
        rd(2'd1, 32'h118, "status_tx_overflow");
        wait_tx(600);
        rd(2'd1, 32'h104, "status_txovr_sticky");
        wr(2'd3, 32'h4);
        chk("irq_err", 32'(irq), 1);
        wr(2'd1, 32'h100);
        chk("irq_err_clear", 32'(irq), 0);
        rd(2'd1, 32'h4, "status_txovr_clear");

        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        rd(2'd1, 32'h4, "status_glitch");

        wr(2'd3, 32'h18);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        rd(2'd1, 32'h0001_0085, "status_perr");
        rd(2'd0, 32'h01, "rx_perr_byte");
        wr(2'd1, 32'h80);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        rd(2'd1, 32'h44, "status_ferr");
        rd(2'd0, 32'h100, "rx_ferr_dropped");
        wr(2'd1, 32'h40);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        rd(2'd1, 32'h0001_0005, "status_par_ok");
        rd(2'd0, 32'h5A, "rx_par_ok_byte");

        repeat (5) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        chk("tx_none_left", txe_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
